// File: rtl/conv_tile_scheduler.sv
// Multi-filter tile scheduler: latches one input tile, issues it with each banked kernel to a PE,
// and queues filter-tagged results in a FWFT FIFO. Optional ReLU on results: CONV_SCHED_RELU_EN.
module conv_tile_scheduler #(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int CHANNELS          = 3,
  parameter int NUM_FILTERS       = 4,
  parameter int OUT_FIFO_DEPTH    = 8,
  localparam int TW  = CHANNELS * INPUT_TILE_SIZE * INPUT_TILE_SIZE * INPUT_DATA_WIDTH,
  localparam int KW  = KERNEL_SIZE * KERNEL_SIZE * KERNEL_DATA_WIDTH * CHANNELS,
  localparam int LW  = INPUT_DATA_WIDTH + KERNEL_DATA_WIDTH + 13,
  localparam int NL  = (INPUT_TILE_SIZE - KERNEL_SIZE + 1) * (INPUT_TILE_SIZE - KERNEL_SIZE + 1),
  localparam int RW  = NL * LW,
  localparam int FW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int AW  = $clog2(OUT_FIFO_DEPTH),
  localparam int LVW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_k_wr_en,
  input  logic [FW-1:0] i_k_wr_addr,
  input  logic [KW-1:0] i_k_wr_data,
  output logic          o_k_wr_err,
  input  logic [TW-1:0] i_tile_in,
  input  logic          i_tile_valid,
  output logic          o_proc_finish,
  output logic          o_pe_start,
  output logic [TW-1:0] o_pe_tile,
  output logic [KW-1:0] o_pe_kernel,
  input  logic          i_pe_done,
  input  logic [RW-1:0] i_pe_result,
  output logic [RW-1:0] o_out_data,
  output logic [FW-1:0] o_out_filter_idx,
  output logic          o_out_last,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [LVW-1:0] o_fifo_level,
  output logic          o_busy,
  output logic [15:0]   o_tile_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StPush, StFinish, StGap} state_t;

  state_t        r_state;
  logic [FW-1:0] r_idx;
  logic [RW-1:0] r_hold;
  logic [KW-1:0] r_bank [NUM_FILTERS];
  logic          r_pe_start;
  logic          r_proc_finish;
  logic          r_k_wr_err;
  logic [TW-1:0] r_pe_tile;
  logic [KW-1:0] r_pe_kernel;
  logic [15:0]   r_tile_count;

  logic [RW-1:0]  r_fifo_data [OUT_FIFO_DEPTH];
  logic [FW-1:0]  r_fifo_idx  [OUT_FIFO_DEPTH];
  logic           r_fifo_last [OUT_FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LVW-1:0] r_level;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_last;
  logic          w_wr_ok;
  logic [FW-1:0] w_next_idx;
  logic [RW-1:0] w_push_data;

  assign w_full     = (r_level == LVW'(OUT_FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_pop      = !w_empty && i_out_ready;
  assign w_last     = (r_idx == FW'(NUM_FILTERS - 1));
  assign w_push     = (r_state == StPush) && (!w_full || w_pop);
  assign w_next_idx = r_idx + 1'b1;
  assign w_wr_ok    = i_k_wr_en && (r_state == StIdle) &&
                      ({1'b0, i_k_wr_addr} < (FW + 1)'(NUM_FILTERS));

`ifdef CONV_SCHED_RELU_EN
  always_comb begin
    w_push_data = r_hold;
    for (int l = 0; l < NL; l++) begin
      if (r_hold[l*LW + LW - 1]) w_push_data[l*LW +: LW] = '0;
    end
  end
`else
  assign w_push_data = r_hold;
`endif

  // pe_kernel is loaded on entry to ISSUE so it is valid alongside pe_start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_hold        <= '0;
      r_pe_start    <= 1'b0;
      r_proc_finish <= 1'b0;
      r_k_wr_err    <= 1'b0;
      r_pe_tile     <= '0;
      r_pe_kernel   <= '0;
      r_tile_count  <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) r_bank[i] <= '0;
    end else begin
      r_pe_start    <= 1'b0;
      r_proc_finish <= 1'b0;
      r_k_wr_err    <= i_k_wr_en && !w_wr_ok;
      if (w_wr_ok) r_bank[i_k_wr_addr] <= i_k_wr_data;
      unique case (r_state)
        StIdle: begin
          if (i_tile_valid) begin
            r_pe_tile   <= i_tile_in;
            r_idx       <= '0;
            r_pe_kernel <= r_bank[0];
            r_pe_start  <= 1'b1;
            r_state     <= StIssue;
          end
        end
        StIssue: r_state <= StWait;
        StWait: begin
          if (i_pe_done) begin
            r_hold  <= i_pe_result;
            r_state <= StPush;
          end
        end
        StPush: begin
          if (w_push) begin
            if (w_last) begin
              r_proc_finish <= 1'b1;
              r_tile_count  <= r_tile_count + 16'd1;
              r_state       <= StFinish;
            end else begin
              r_idx       <= w_next_idx;
              r_pe_kernel <= r_bank[w_next_idx];
              r_pe_start  <= 1'b1;
              r_state     <= StIssue;
            end
          end
        end
        StFinish: r_state <= StGap;
        StGap:    r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_idx[r_wr_ptr]  <= r_idx;
        r_fifo_last[r_wr_ptr] <= w_last;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + LVW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVW'(1);
    end
  end

  assign o_k_wr_err       = r_k_wr_err;
  assign o_proc_finish    = r_proc_finish;
  assign o_pe_start       = r_pe_start;
  assign o_pe_tile        = r_pe_tile;
  assign o_pe_kernel      = r_pe_kernel;
  assign o_out_data       = r_fifo_data[r_rd_ptr];
  assign o_out_filter_idx = r_fifo_idx[r_rd_ptr];
  assign o_out_last       = r_fifo_last[r_rd_ptr];
  assign o_out_valid      = !w_empty;
  assign o_fifo_level     = r_level;
  assign o_busy           = (r_state != StIdle);
  assign o_tile_count     = r_tile_count;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler (F=4, FIFO depth 2) plus an F=3 instance for range errors.
module tb_conv_tile_scheduler;

  localparam int TW = 384;
  localparam int KW = 216;
  localparam int RW = 116;
  localparam int LW = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          k_wr_en = 1'b0;
  logic [1:0]    k_wr_addr = '0;
  logic [KW-1:0] k_wr_data = '0;
  logic [TW-1:0] tile_in = '0;
  logic          tile_valid = 1'b0;
  logic          pe_done = 1'b0;
  logic [RW-1:0] pe_result = '0;
  logic          out_ready = 1'b0;
  logic          b_en = 1'b0;
  logic [1:0]    b_addr = '0;
  logic          zero = 1'b0;

  logic          o_k_wr_err, o_proc_finish, o_pe_start, o_out_last, o_out_valid, o_busy;
  logic [TW-1:0] o_pe_tile;
  logic [KW-1:0] o_pe_kernel;
  logic [RW-1:0] o_out_data;
  logic [1:0]    o_out_filter_idx, o_fifo_level;
  logic [15:0]   o_tile_count;

  logic          b_err, b_fin, b_start, b_last, b_valid, b_busy;
  logic [TW-1:0] b_tile;
  logic [KW-1:0] b_kernel;
  logic [RW-1:0] b_data;
  logic [1:0]    b_idx, b_level;
  logic [15:0]   b_count;

  conv_tile_scheduler #(.NUM_FILTERS(4), .OUT_FIFO_DEPTH(2)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_k_wr_en(k_wr_en), .i_k_wr_addr(k_wr_addr),
    .i_k_wr_data(k_wr_data), .o_k_wr_err(o_k_wr_err), .i_tile_in(tile_in),
    .i_tile_valid(tile_valid), .o_proc_finish(o_proc_finish), .o_pe_start(o_pe_start),
    .o_pe_tile(o_pe_tile), .o_pe_kernel(o_pe_kernel), .i_pe_done(pe_done),
    .i_pe_result(pe_result), .o_out_data(o_out_data), .o_out_filter_idx(o_out_filter_idx),
    .o_out_last(o_out_last), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_fifo_level(o_fifo_level), .o_busy(o_busy), .o_tile_count(o_tile_count)
  );

  conv_tile_scheduler #(.NUM_FILTERS(3), .OUT_FIFO_DEPTH(2)) u_dut_f3 (
    .i_clk(clk), .i_reset(rst), .i_k_wr_en(b_en), .i_k_wr_addr(b_addr),
    .i_k_wr_data(k_wr_data), .o_k_wr_err(b_err), .i_tile_in(tile_in),
    .i_tile_valid(zero), .o_proc_finish(b_fin), .o_pe_start(b_start),
    .o_pe_tile(b_tile), .o_pe_kernel(b_kernel), .i_pe_done(zero),
    .i_pe_result(pe_result), .o_out_data(b_data), .o_out_filter_idx(b_idx),
    .o_out_last(b_last), .o_out_valid(b_valid), .i_out_ready(zero),
    .o_fifo_level(b_level), .o_busy(b_busy), .o_tile_count(b_count)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [KW-1:0] kern(input int i);
    logic [7:0] b;
    b = 8'(17 * (i + 1));
    return {(KW/8){b}};
  endfunction

  function automatic logic [TW-1:0] tile(input int n);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(n);
    return {(TW/32){w}};
  endfunction

  // PE output for filter j; lane 0 optionally -5.
  function automatic logic [RW-1:0] pe_res(input int j, input logic neg);
    logic [LW-1:0] l0;
    l0 = neg ? 29'h1FFF_FFFB : 29'(j + 10);
    return {29'(j + 40), 29'(j + 30), 29'(j + 20), l0};
  endfunction

  function automatic logic [RW-1:0] exp_out(input int j, input logic neg);
    logic [RW-1:0] r;
    r = pe_res(j, neg);
`ifdef CONV_SCHED_RELU_EN
    if (neg) r[LW-1:0] = '0;
`endif
    return r;
  endfunction

  int start_cnt = 0, fin_cnt = 0, busy_cnt = 0;
  int resp = 0, pe_limit = 1000, pe_j = 0;
  logic pe_neg = 1'b0;
  logic [KW-1:0] kq[$];
  logic [RW-1:0] pop_data[$];
  logic [1:0]    pop_idx[$];
  logic          pop_last[$];

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_pe_start) begin
          start_cnt++;
          kq.push_back(o_pe_kernel);
        end
        if (o_proc_finish) fin_cnt++;
        if (o_busy) busy_cnt++;
        if (o_out_valid && out_ready) begin
          pop_data.push_back(o_out_data);
          pop_idx.push_back(o_out_filter_idx);
          pop_last.push_back(o_out_last);
        end
      end
    end
  end

  // PE: pe_done two cycles after pe_start.
  initial begin : pe_model
    forever begin
      @(negedge clk);
      if (!rst && o_pe_start && resp < pe_limit) begin
        resp++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pe_done = 1'b1;
        pe_result = pe_res(pe_j, pe_neg);
        @(posedge clk); #1;
        pe_done = 1'b0;
        pe_j++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_tile(input int n, input logic ready);
    tick();
    tile_in = tile(n);
    tile_valid = 1'b1;
    out_ready = ready;
    pe_j = 0;
    start_cnt = 0;
    busy_cnt = 0;
    kq.delete();
    pop_data.delete();
    pop_idx.delete();
    pop_last.delete();
    repeat (2) @(negedge clk);
    check($sformatf("latch_busy_t%0d", n), TW'(o_busy), TW'(1));
    check($sformatf("latch_tile_t%0d", n), o_pe_tile, tile(n));
  endtask

  task automatic wait_finish(input string tag);
    int f0 = fin_cnt;
    int n = 0;
    while (fin_cnt == f0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, TW'(fin_cnt - f0), TW'(1));
  endtask

  task automatic wait_level(input string tag, input int lvl);
    int n = 0;
    while (int'(o_fifo_level) != lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, TW'(o_fifo_level), TW'(lvl));
  endtask

  task automatic check_tile(input string t, input logic neg);
    check({t, "_pops"}, TW'(pop_data.size()), TW'(4));
    check({t, "_starts"}, TW'(kq.size()), TW'(4));
    for (int j = 0; j < 4 && j < pop_data.size(); j++) begin
      check($sformatf("%s_idx%0d", t, j), TW'(pop_idx[j]), TW'(j));
      check($sformatf("%s_last%0d", t, j), TW'(pop_last[j]), TW'(j == 3));
      check($sformatf("%s_data%0d", t, j), TW'(pop_data[j]), TW'(exp_out(j, neg)));
    end
  endtask

  initial begin : main
    int f0;
    #3;
    check("rst_busy", TW'(o_busy), TW'(0));
    check("rst_valid", TW'(o_out_valid), TW'(0));
    check("rst_level", TW'(o_fifo_level), TW'(0));
    check("rst_count", TW'(o_tile_count), TW'(0));
    check("rst_tile", o_pe_tile, TW'(0));
    check("rst_kernel", TW'(o_pe_kernel), TW'(0));
    check("rst_start", TW'({o_pe_start, o_proc_finish, o_k_wr_err}), TW'(0));
    tick();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      k_wr_en = 1'b1;
      k_wr_addr = 2'(i);
      k_wr_data = kern(i);
    end
    tick();
    k_wr_en = 1'b0;
    @(negedge clk);
    check("wr_ok_err", TW'(o_k_wr_err), TW'(0));

    // Tile 1: tile_valid held through FINISH, dropped during GAP.
    tick();
    tile_in = tile(1);
    tile_valid = 1'b1;
    out_ready = 1'b1;
    pe_j = 0;
    start_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
    check("t1_idle", TW'(o_busy), TW'(0));
    @(negedge clk);
    check("t1_start", TW'(o_pe_start), TW'(1));
    check("t1_tile", o_pe_tile, tile(1));
    check("t1_kernel0", TW'(o_pe_kernel), TW'(kern(0)));
    wait_finish("t1_finish");
    tick();
    tile_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t1_count", TW'(o_tile_count), TW'(1));
    check("t1_idle_after", TW'(o_busy), TW'(0));
    check("t1_busy_cycles", TW'(busy_cnt), TW'(18));
    check_tile("t1", 1'b0);
    for (int j = 0; j < 4 && j < kq.size(); j++)
      check($sformatf("t1_kernel%0d", j), TW'(kq[j]), TW'(kern(j)));

    // Tile 2: consumer stalls, FIFO of 2 fills, FSM holds in PUSH.
    start_tile(2, 1'b0);
    tick();
    tile_valid = 1'b0;
    wait_level("t2_fill", 2);
    f0 = fin_cnt;
    repeat (6) @(negedge clk);
    check("t2_stall_level", TW'(o_fifo_level), TW'(2));
    check("t2_stall_starts", TW'(start_cnt), TW'(3));
    check("t2_stall_busy", TW'(o_busy), TW'(1));
    check("t2_stall_nopop", TW'(pop_data.size()), TW'(0));
    check("t2_stall_nofin", TW'(fin_cnt), TW'(f0));
    tick();
    out_ready = 1'b1;
    wait_finish("t2_finish");
    repeat (4) @(negedge clk);
    check_tile("t2", 1'b0);
    check("t2_count", TW'(o_tile_count), TW'(2));

    // Tile 3: kernel write while busy is rejected and leaves the bank intact.
    start_tile(3, 1'b1);
    tick();
    tile_valid = 1'b0;
    k_wr_en = 1'b1;
    k_wr_addr = 2'd0;
    k_wr_data = '1;
    tick();
    k_wr_en = 1'b0;
    @(negedge clk);
    check("busy_wr_err", TW'(o_k_wr_err), TW'(1));
    @(negedge clk);
    check("busy_wr_err_clr", TW'(o_k_wr_err), TW'(0));
    wait_finish("t3_finish");
    repeat (4) @(negedge clk);
    check_tile("t3", 1'b0);
    for (int j = 0; j < 4 && j < kq.size(); j++)
      check($sformatf("t3_kernel%0d", j), TW'(kq[j]), TW'(kern(j)));

    // F=3 instance: addr 3 out of range, addr 2 accepted.
    tick();
    b_en = 1'b1;
    b_addr = 2'd3;
    tick();
    b_en = 1'b0;
    @(negedge clk);
    check("range_err", TW'(b_err), TW'(1));
    tick();
    b_en = 1'b1;
    b_addr = 2'd2;
    tick();
    b_en = 1'b0;
    @(negedge clk);
    check("range_ok", TW'(b_err), TW'(0));

    // Tile 4: reset while waiting on filter 1 with one FIFO entry.
    pe_limit = resp + 1;
    start_tile(4, 1'b0);
    tick();
    tile_valid = 1'b0;
    wait_level("t4_one", 1);
    begin
      int n = 0;
      while (start_cnt < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t4_second_issue", TW'(start_cnt), TW'(2));
    repeat (2) @(negedge clk);
    check("t4_valid_pre", TW'(o_out_valid), TW'(1));
    f0 = fin_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", TW'(o_out_valid), TW'(0));
    check("mid_rst_level", TW'(o_fifo_level), TW'(0));
    check("mid_rst_busy", TW'(o_busy), TW'(0));
    check("mid_rst_tile", o_pe_tile, TW'(0));
    check("mid_rst_kernel", TW'(o_pe_kernel), TW'(0));
    check("mid_rst_count", TW'(o_tile_count), TW'(0));
    tick();
    tick();
    rst = 1'b0;
    pe_limit = 1000;
    repeat (3) @(negedge clk);
    check("mid_rst_nofin", TW'(fin_cnt), TW'(f0));

    // Tile 5: restarts at idx 0 with a cleared bank; lane 0 of every result is -5.
    pe_neg = 1'b1;
    start_tile(5, 1'b1);
    tick();
    tile_valid = 1'b0;
    wait_finish("t5_finish");
    repeat (4) @(negedge clk);
    check_tile("t5", 1'b1);
    if (kq.size() > 0) check("t5_kernel_cleared", TW'(kq[0]), TW'(0));
    if (pop_data.size() > 0) begin
`ifdef CONV_SCHED_RELU_EN
      check("relu_lane0", TW'(pop_data[0][LW-1:0]), TW'(0));
`else
      check("relu_lane0", TW'(pop_data[0][LW-1:0]), TW'(29'h1FFF_FFFB));
`endif
    end
    check("t5_count", TW'(o_tile_count), TW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Multi-filter tile scheduler between the input tile buffer (`input_control_unit`) and a single PE. It latches one multi-channel input tile and holds `NUM_FILTERS` kernels in an internal bank. For each filter in turn it issues the tile and that filter's kernel to the PE. Each PE result is tagged with its filter index and buffered in an output FIFO. After the last filter it pulses `proc_finish` upstream to request the next tile.

## Interface
- `KERNEL_SIZE`, 3, kernel side K
- `INPUT_TILE_SIZE`, 4, tile side n
- `INPUT_DATA_WIDTH`, 8, pixel width IDW
- `KERNEL_DATA_WIDTH`, 8, weight width KDW
- `CHANNELS`, 3, input channels C
- `NUM_FILTERS`, 4, kernels in bank F (≥1)
- `OUT_FIFO_DEPTH`, 8, output FIFO entries, power of 2 (≥2)
- Derived: TW = C·n·n·IDW; KW = K·K·KDW·C; RW = (n−K+1)²·(IDW+KDW+13); FW = max(1, clog2 F)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `k_wr_en` in 1: kernel bank write strobe
- `k_wr_addr` in FW: filter index to write
- `k_wr_data` in KW: signed kernel, all channels
- `k_wr_err` out 1: one-cycle pulse when a write is rejected
- `tile_in` in TW: flattened input tile
- `tile_valid` in 1: tile present (upstream `o_ready`)
- `proc_finish` out 1: one-cycle pulse, tile fully processed
- `pe_start` out 1: one-cycle PE start pulse
- `pe_tile` out TW: latched tile to PE
- `pe_kernel` out KW: registered kernel to PE
- `pe_done` in 1: PE result valid
- `pe_result` in RW: signed packed PE output
- `out_data` out RW: FIFO head result
- `out_filter_idx` out FW: filter index of head
- `out_last` out 1: head is the tile's last filter
- `out_valid` out 1: FIFO not empty
- `out_ready` in 1: consumer accepts head
- `fifo_level` out clog2(OUT_FIFO_DEPTH)+1: FIFO occupancy
- `busy` out 1: state ≠ IDLE
- `tile_count` out 16: tiles completed, wraps at 2¹⁶

## Operation
- FSM states: IDLE, ISSUE, WAIT, PUSH, FINISH, GAP.
- IDLE: if `tile_valid` is high, latch `tile_in` into `pe_tile`, clear filter index to 0, and go to ISSUE.
- ISSUE: register `pe_kernel` ← bank[idx], assert `pe_start` for this cycle only, then go to WAIT.
- WAIT: `pe_done` is sampled only in this state. On `pe_done`, capture `pe_result` into a hold register and go to PUSH. There is no timeout.
- PUSH: write {last = (idx==F−1), idx, hold} when the FIFO is not full, or when it is full and a pop happens in the same cycle. Otherwise stall in PUSH. On a write, go to FINISH if last, else increment idx and go to ISSUE.
- FINISH: pulse `proc_finish`, increment `tile_count`, go to GAP.
- GAP: one dead cycle in which `tile_valid` is ignored. Upstream must drop `tile_valid` in the cycle after `proc_finish`. Then go to IDLE.
- Kernel bank writes take effect only in IDLE with `k_wr_addr` < F.
  - A write in any other state, or to an out-of-range address, is dropped and pulses `k_wr_err` on the next cycle.
- FIFO is first-word-fall-through: pop when `out_valid` && `out_ready`. Pop on empty is ignored. Pointers wrap modulo depth.
- `pe_done` arriving outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `pe_tile`, `pe_kernel` and `tile_count`.
  - Kernel bank all zero, FIFO empty.
- Reset asserted mid-tile aborts the tile: FIFO contents and the hold register are discarded, and no `proc_finish` is issued.
- `pe_start` is asserted exactly one cycle after tile latch, and one cycle after each non-last PUSH write.
- Minimum per filter: 3 cycles (ISSUE, WAIT with `pe_done`, PUSH).
- FIFO entry is visible on `out_valid` the cycle after the PUSH write.
- `proc_finish` is asserted the cycle after the last PUSH write. Minimum tile turnaround is 3F+3 cycles from IDLE latch back to IDLE.
- Simultaneous push and pop keeps `fifo_level` unchanged. This is legal even when the FIFO is full.

## Configuration
- `CONV_SCHED_RELU_EN` defined: before the FIFO write, each (IDW+KDW+13)-bit signed lane of the hold register with its sign bit set is replaced by 0.
- Not defined: results are stored unmodified. No other behaviour changes.

## Test plan
- Reset, write kernels for F=4 at idx 0..3 in IDLE, present one tile, and model the PE with `pe_done` 2 cycles after `pe_start` → 4 `pe_start` pulses with `pe_kernel` = bank[0..3] in order, 4 FIFO entries with idx 0..3, `out_last` only on idx 3, one `proc_finish`, `tile_count`=1.
- Hold `out_ready`=0 with `OUT_FIFO_DEPTH`=2 and F=4 → FSM stalls in PUSH with `fifo_level`=2. Raise `out_ready` → remaining entries drain in order with no loss or duplication.
- Hold `tile_valid` high through FINISH and release it the cycle after `proc_finish` → exactly one tile processed and no re-latch during GAP.
- `k_wr_en` while busy, and in IDLE with addr=F → `k_wr_err` pulses each time and the bank is unchanged (read back via the next tile's `pe_kernel`).
- Assert `reset` while in WAIT with 1 FIFO entry → outputs go to 0 immediately, `out_valid`=0, and no `proc_finish`. The next tile starts again from idx 0.
- With RELU on, a `pe_result` lane of −5 → that lane reads 0 in `out_data`. With RELU off, the same stimulus → the lane reads −5.
